sdram_write: RTL
================

SDRAM_WRITE -- requirements
Module: sdram_write

Interface
REQ-001 SHALL have parameter T_RCD, default 3, meaning cycles between ACTIVE and WRITE (range 1..15).
REQ-002 SHALL have parameter T_WRP, default 4, meaning cycles from WRITE until ofin (tWR+tRP, range 1..15).
REQ-003 SHALL have port iclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port ireset_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port ireq, input, 1, write request, sampled in IDLE only.
REQ-006 SHALL have port ienb, input, 1, bus ownership; low puts every DRAM_* output at high-Z.
REQ-007 SHALL have port ofin, output, 1, one-cycle pulse when the write has completed.
REQ-008 SHALL have port obusy, output, 1, high in every state except IDLE.
REQ-009 SHALL have ports irow (13), icolumn (10), ibank (2), idata (16), all inputs, giving target address and write data.
REQ-010 SHALL have outputs DRAM_CLK, DRAM_CKE, DRAM_ADDR[12:0], DRAM_BA[1:0], DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, DRAM_LDQM, DRAM_UDQM, and inout DRAM_DQ[15:0].

Function
REQ-011 SHALL implement states IDLE, ACTIVATE, WAIT_RCD, WRITE, WAIT_WRP, DONE, with the command registered on iclk.
REQ-012 SHALL go IDLE->ACTIVATE on ireq=1, and capture irow/icolumn/ibank/idata on that same edge.
REQ-013 SHALL make ACTIVATE, WRITE and DONE last exactly one cycle each; ACTIVATE->WAIT_RCD, WRITE->WAIT_WRP, DONE->IDLE.
REQ-014 SHALL keep WAIT_RCD for T_RCD-1 cycles and WAIT_WRP for T_WRP-1 cycles (zero cycles when the parameter is 1), using a 4-bit counter cleared on state entry.
REQ-015 SHALL drive command {CS_N,RAS_N,CAS_N,WE_N} as follows: ACTIVATE 0011, WRITE 0100, all other states 0111 (NOP).
REQ-016 SHALL drive in ACTIVATE: ADDR=captured row, BA=captured bank.
REQ-017 SHALL drive in WRITE: ADDR={3'b001,captured column} (A10=1, auto-precharge), BA=captured bank, DQM=00, DQ=captured data.
REQ-018 SHALL drive in all other states: ADDR=0, BA=0, DQM=11, DQ high-Z.
REQ-019 SHALL put DRAM_DQ at high-Z in every cycle except WRITE with ienb=1.
REQ-020 SHALL assert ofin only in DONE; request to ofin latency = 3+T_RCD+T_WRP-2 cycles (default 8).
REQ-021 SHALL ignore ireq and input changes while obusy=1; ireq held high in DONE starts a new write at the IDLE cycle after DONE.
REQ-022 SHALL drive DRAM_CLK=~iclk and DRAM_CKE=1 when ienb=1.
REQ-023 SHALL keep the FSM advancing when ienb=0; the controlling arbiter guarantees ienb=1 for the whole busy interval.

Reset
REQ-024 SHALL, on ireset_n=0 at any time (including mid-write), force state=IDLE immediately, counter=0, ofin=0, obusy=0, command=0111, ADDR=0, BA=0, DQM=11, DQ high-Z, captured registers=0.
REQ-025 SHALL resume normal operation on the first iclk edge after ireset_n deasserts.

Configuration
REQ-026 SHALL, with SDRAM_WRITE_BYTE_MASK_EN defined, add input ibyteen[1:0] (bit1=upper, bit0=lower), captured with ireq, and drive DQM=~ibyteen_captured in WRITE.
REQ-027 SHALL, without SDRAM_WRITE_BYTE_MASK_EN, omit ibyteen and drive DQM=00 in WRITE.

Structure
REQ-028 SHALL take the command encodings (NOP, ACTIVE, WRITE), the state encodings and the A10 auto-precharge constant from shared package sdram_pkg, which the read path also uses.
REQ-029 SHALL instantiate the wait counter as sub-module sdram_wait_ctr (clear, enable, terminal-count input, done output).

Verification
REQ-030 SHALL verify a default write: ireq with row=0x0123, col=0x045, bank=2, data=0xBEEF -> ACTIVE (ADDR 0x0123, BA 2), WRITE 3 cycles later (ADDR 0x0445, DQ 0xBEEF, DQM 00), ofin 8 cycles after the request.
REQ-031 SHALL verify tri-state: ienb=0 throughout -> all DRAM_* high-Z and ofin still pulses on schedule.
REQ-032 SHALL verify reset mid-op: ireset_n low during WAIT_RCD -> immediate NOP and IDLE, no WRITE issued, ofin never pulses.
REQ-033 SHALL verify back-to-back: ireq held high across two writes -> two ACTIVE/WRITE pairs, one ofin each, one IDLE cycle between them.
REQ-034 SHALL verify the byte mask: with SDRAM_WRITE_BYTE_MASK_EN and ibyteen=01 -> UDQM=1, LDQM=0 in WRITE.
REQ-035 SHALL verify minimum timing: T_RCD=1, T_WRP=1 -> WRITE in the cycle right after ACTIVE, and latency = 3 cycles.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: FSM states, command encodings and
// address constants used by both the read and write paths.
package sdram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACTIVATE = 3'd1,
      ST_WAIT_RCD = 3'd2,
      ST_WRITE    = 3'd3,
      ST_WAIT_WRP = 3'd4,
      ST_DONE     = 3'd5
   } sdram_state_e;

   // {CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [3:0] CMD_NOP    = 4'b0111;
   localparam logic [3:0] CMD_ACTIVE = 4'b0011;
   localparam logic [3:0] CMD_WRITE  = 4'b0100;

   // ADDR[12:10] during a column command; A10 set selects auto-precharge
   localparam logic [2:0] ADDR_HI_AP = 3'b001;

   localparam logic [1:0] DQM_ALL  = 2'b11;
   localparam logic [1:0] DQM_NONE = 2'b00;

   // Terminal count for a wait state of (cycles-1) cycles; counter starts at 0
   function automatic logic [3:0] wait_tc(input int unsigned cycles);
      logic [3:0] tc;
      if (cycles > 32'd1) begin
         tc = 4'(cycles - 32'd2);
      end else begin
         tc = 4'd0;
      end
      return tc;
   endfunction

endpackage

// File: rtl/sdram_wait_ctr.sv
// Wait-state counter: cleared on state entry, counts while enabled and
// flags done when it reaches the terminal count.
module sdram_wait_ctr (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [3:0] tc_i,
   output logic       done_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   assign done_o = (cnt_q == tc_i);

   // Next count: clear wins, saturate once terminal count is reached
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 4'd0;
      end else if (en_i && !done_o) begin
         cnt_d = cnt_q + 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sdram_write.sv
// Single-word SDRAM write with auto-precharge. Optional per-byte write
// masking is enabled by defining SDRAM_WRITE_BYTE_MASK_EN.
module sdram_write
   import sdram_pkg::*;
#(
   parameter int unsigned T_RCD = 3,
   parameter int unsigned T_WRP = 4
) (
   input  logic        iclk,
   input  logic        ireset_n,
   input  logic        ireq,
   input  logic        ienb,
   output logic        ofin,
   output logic        obusy,
   input  logic [12:0] irow,
   input  logic [9:0]  icolumn,
   input  logic [1:0]  ibank,
   input  logic [15:0] idata,
`ifdef SDRAM_WRITE_BYTE_MASK_EN
   input  logic [1:0]  ibyteen,
`endif
   output logic        DRAM_CLK,
   output logic        DRAM_CKE,
   output logic [12:0] DRAM_ADDR,
   output logic [1:0]  DRAM_BA,
   output logic        DRAM_CS_N,
   output logic        DRAM_RAS_N,
   output logic        DRAM_CAS_N,
   output logic        DRAM_WE_N,
   output logic        DRAM_LDQM,
   output logic        DRAM_UDQM,
   inout  wire  [15:0] DRAM_DQ
);

   localparam logic [3:0] RCD_TC = wait_tc(T_RCD);
   localparam logic [3:0] WRP_TC = wait_tc(T_WRP);

   sdram_state_e state_q, state_d;
   logic [12:0] row_q, row_d;
   logic [9:0]  col_q, col_d;
   logic [1:0]  bank_q, bank_d;
   logic [15:0] data_q, data_d;
   logic [1:0]  wmask_q, wmask_d;
   logic [3:0]  cmd_q, cmd_d;
   logic [12:0] addr_q, addr_d;
   logic [1:0]  ba_q, ba_d;
   logic [1:0]  dqm_q, dqm_d;
   logic        dq_oe_q, dq_oe_d;
   logic        ofin_q, ofin_d;
   logic        obusy_q, obusy_d;
   logic        capture_s;
   logic        wait_done_s;
   logic        wait_en_s;
   logic [3:0]  wait_tc_s;

   assign capture_s = (state_q == ST_IDLE) && ireq;
   assign wait_en_s = (state_q == ST_WAIT_RCD) || (state_q == ST_WAIT_WRP);
   assign wait_tc_s = (state_q == ST_WAIT_WRP) ? WRP_TC : RCD_TC;

   sdram_wait_ctr u_wait_ctr (
      .clk_i  (iclk),
      .rst_ni (ireset_n),
      .clr_i  (state_d != state_q),
      .en_i   (wait_en_s),
      .tc_i   (wait_tc_s),
      .done_o (wait_done_s)
   );

   // Next state; a parameter of 1 skips its wait state entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     state_d = ireq ? ST_ACTIVATE : ST_IDLE;
         ST_ACTIVATE: state_d = (T_RCD > 32'd1) ? ST_WAIT_RCD : ST_WRITE;
         ST_WAIT_RCD: state_d = wait_done_s ? ST_WRITE : ST_WAIT_RCD;
         ST_WRITE:    state_d = (T_WRP > 32'd1) ? ST_WAIT_WRP : ST_DONE;
         ST_WAIT_WRP: state_d = wait_done_s ? ST_DONE : ST_WAIT_WRP;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Request capture; held stable for the whole busy interval
   always_comb begin
      row_d   = capture_s ? irow    : row_q;
      col_d   = capture_s ? icolumn : col_q;
      bank_d  = capture_s ? ibank   : bank_q;
      data_d  = capture_s ? idata   : data_q;
`ifdef SDRAM_WRITE_BYTE_MASK_EN
      wmask_d = capture_s ? ~ibyteen : wmask_q;
`else
      wmask_d = DQM_NONE;
`endif
   end

   // Bus outputs decoded from the upcoming state so they register with it
   always_comb begin
      cmd_d   = CMD_NOP;
      addr_d  = 13'd0;
      ba_d    = 2'd0;
      dqm_d   = DQM_ALL;
      dq_oe_d = 1'b0;
      case (state_d)
         ST_ACTIVATE: begin
            cmd_d  = CMD_ACTIVE;
            addr_d = row_d;
            ba_d   = bank_d;
         end
         ST_WRITE: begin
            cmd_d   = CMD_WRITE;
            addr_d  = {ADDR_HI_AP, col_d};
            ba_d    = bank_d;
            dqm_d   = wmask_d;
            dq_oe_d = 1'b1;
         end
         default: begin
            cmd_d   = CMD_NOP;
            dq_oe_d = 1'b0;
         end
      endcase
      ofin_d  = (state_d == ST_DONE);
      obusy_d = (state_d != ST_IDLE);
   end

   // State, capture and output registers
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state_q <= ST_IDLE;
         row_q   <= 13'd0;
         col_q   <= 10'd0;
         bank_q  <= 2'd0;
         data_q  <= 16'd0;
         wmask_q <= DQM_NONE;
         cmd_q   <= CMD_NOP;
         addr_q  <= 13'd0;
         ba_q    <= 2'd0;
         dqm_q   <= DQM_ALL;
         dq_oe_q <= 1'b0;
         ofin_q  <= 1'b0;
         obusy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         bank_q  <= bank_d;
         data_q  <= data_d;
         wmask_q <= wmask_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
         dqm_q   <= dqm_d;
         dq_oe_q <= dq_oe_d;
         ofin_q  <= ofin_d;
         obusy_q <= obusy_d;
      end
   end

   assign ofin  = ofin_q;
   assign obusy = obusy_q;

   assign DRAM_CLK   = ienb ? ~iclk      : 1'bz;
   assign DRAM_CKE   = ienb ? 1'b1       : 1'bz;
   assign DRAM_ADDR  = ienb ? addr_q     : {13{1'bz}};
   assign DRAM_BA    = ienb ? ba_q       : {2{1'bz}};
   assign DRAM_CS_N  = ienb ? cmd_q[3]   : 1'bz;
   assign DRAM_RAS_N = ienb ? cmd_q[2]   : 1'bz;
   assign DRAM_CAS_N = ienb ? cmd_q[1]   : 1'bz;
   assign DRAM_WE_N  = ienb ? cmd_q[0]   : 1'bz;
   assign DRAM_LDQM  = ienb ? dqm_q[0]   : 1'bz;
   assign DRAM_UDQM  = ienb ? dqm_q[1]   : 1'bz;
   assign DRAM_DQ    = (ienb && dq_oe_q) ? data_q : {16{1'bz}};

endmodule
